uart_apb_master_arb: RTL and testbench

APB master that shares the UART's single APB slave port between two requesters: a configuration requester (port 0, baud/control/interrupt setup) and a data requester (port 1, TX/RX FIFO traffic). It arbitrates round-robin, sequences each request through the APB SETUP/ACCESS phases, waits on Pready, bounds the wait with a timeout, and returns read data and error status to the winning requester. It sits between the UART's internal command sources and the UART APB slave. Its APB outputs drive the same signals a bench driver drives today.

---
 rtl/uart_apb_master_arb_if.sv | 38 +++
 rtl/uart_apb_master_arb.sv | 115 +++++++++++
 tb/tb_uart_apb_master_arb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_master_arb_if.sv
// Bundle of requester-side and APB-side signals for the UART APB master arbiter.
// The master modport is the arbiter's view and the slave modport is the view from the requesters and the APB slave.
interface uart_apb_master_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req;
    logic [1:0]        req_write;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] Paddr;
    logic              Psel;
    logic              Penable;
    logic              Pwrite;
    logic [DATA_W-1:0] Pwdata;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;
    logic              Pslverr;

    modport master (
        input  req, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  Prdata, Pready, Pslverr,
        output done, rsp_rdata, rsp_err,
        output Paddr, Psel, Penable, Pwrite, Pwdata
    );

    modport slave (
        output req, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output Prdata, Pready, Pslverr,
        input  done, rsp_rdata, rsp_err,
        input  Paddr, Psel, Penable, Pwrite, Pwdata
    );
endinterface

// File: rtl/uart_apb_master_arb.sv
// Round-robin APB master that shares the UART APB slave port between a config requester (0) and a data requester (1).
// It also bounds each ACCESS phase with a wait-state timeout.
module uart_apb_master_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic                   clk,
    input logic                   Preset,
    uart_apb_master_arb_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              gnt;

    // The last-grant pointer resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (Preset) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        owner_d  = owner_q;
        last_d   = last_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        done_d   = '0;
        rdata_d  = '0;
        err_d    = 1'b0;

        if (bus.req == 2'b11) begin
            gnt = ~last_q;
        end else begin
            gnt = ~bus.req[0];
        end

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = SETUP;
                    owner_d  = gnt;
                    last_d   = gnt;
                    paddr_d  = gnt ? bus.req_addr1 : bus.req_addr0;
                    pwdata_d = gnt ? bus.req_wdata1 : bus.req_wdata0;
                    pwrite_d = bus.req_write[gnt];
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.Pready) begin
                    state_d         = IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d           = bus.Pslverr;
                    rdata_d         = pwrite_q ? '0 : bus.Prdata;
                end else if (wait_q == WAIT_MAX) begin
                    state_d         = IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.Penable   = (state_q == ACCESS);
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.done      = done_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_uart_apb_master_arb.sv
// Directed bench for uart_apb_master_arb: each step drives the requesters and the APB slave,
// then compares the outputs one cycle at a time against hand-computed values.
module tb_uart_apb_master_arb;
    logic clk;
    logic Preset;
    int   total;
    int   bad;

    uart_apb_master_arb_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

    uart_apb_master_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk    (clk),
        .Preset (Preset),
        .bus    (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] writeV,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] wd0, input logic [31:0] wd1);
        busIf.req        = reqV;
        busIf.req_write  = writeV;
        busIf.req_addr0  = a0;
        busIf.req_addr1  = a1;
        busIf.req_wdata0 = wd0;
        busIf.req_wdata1 = wd1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] expAddr;
        logic [1:0]  expDone;
        total = 0;
        bad   = 0;
        Preset = 1'b1;
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        busIf.Prdata  = 32'h0;
        busIf.Pready  = 1'b0;
        busIf.Pslverr = 1'b0;
        tick();
        tick();
        Preset = 1'b0;
        checkOutput("rst_psel", 32'(busIf.Psel), 32'd0);
        checkOutput("rst_penable", 32'(busIf.Penable), 32'd0);
        checkOutput("rst_paddr", busIf.Paddr, 32'd0);
        checkOutput("rst_pwdata", busIf.Pwdata, 32'd0);
        checkOutput("rst_pwrite", 32'(busIf.Pwrite), 32'd0);
        checkOutput("rst_done", 32'(busIf.done), 32'd0);
        checkOutput("rst_rdata", busIf.rsp_rdata, 32'd0);
        checkOutput("rst_err", 32'(busIf.rsp_err), 32'd0);

        $display("[TB] single write, zero wait");
        applyStimulus(2'b01, 2'b01, 32'h0C, 32'h0, 32'h83, 32'h0);
        busIf.Pready = 1'b1;
        tick();
        checkOutput("wr_setup_psel", 32'(busIf.Psel), 32'd1);
        checkOutput("wr_setup_penable", 32'(busIf.Penable), 32'd0);
        checkOutput("wr_setup_paddr", busIf.Paddr, 32'h0C);
        checkOutput("wr_setup_pwdata", busIf.Pwdata, 32'h83);
        checkOutput("wr_setup_pwrite", 32'(busIf.Pwrite), 32'd1);
        busIf.Pslverr = 1'b1;
        tick();
        busIf.Pslverr = 1'b0;
        checkOutput("wr_access_psel", 32'(busIf.Psel), 32'd1);
        checkOutput("wr_access_penable", 32'(busIf.Penable), 32'd1);
        checkOutput("wr_access_pwdata", busIf.Pwdata, 32'h83);
        checkOutput("wr_access_done", 32'(busIf.done), 32'd0);
        tick();
        busIf.req = 2'b00;
        checkOutput("wr_done", 32'(busIf.done), 32'b01);
        checkOutput("wr_err", 32'(busIf.rsp_err), 32'd0);
        checkOutput("wr_rdata", busIf.rsp_rdata, 32'd0);
        checkOutput("wr_done_psel", 32'(busIf.Psel), 32'd0);
        tick();
        checkOutput("wr_after_done", 32'(busIf.done), 32'd0);
        checkOutput("wr_after_psel", 32'(busIf.Psel), 32'd0);

        $display("[TB] read with two wait states");
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        busIf.Pready = 1'b0;
        busIf.Prdata = 32'h5A;
        tick();
        checkOutput("rd_setup_paddr", busIf.Paddr, 32'h0);
        checkOutput("rd_setup_pwrite", 32'(busIf.Pwrite), 32'd0);
        busIf.req_addr1 = 32'h44;
        tick();
        checkOutput("rd_access_penable", 32'(busIf.Penable), 32'd1);
        checkOutput("rd_addr_held", busIf.Paddr, 32'h0);
        tick();
        checkOutput("rd_wait1_done", 32'(busIf.done), 32'd0);
        checkOutput("rd_wait1_penable", 32'(busIf.Penable), 32'd1);
        tick();
        checkOutput("rd_wait2_done", 32'(busIf.done), 32'd0);
        busIf.Pready = 1'b1;
        tick();
        busIf.req = 2'b00;
        checkOutput("rd_done", 32'(busIf.done), 32'b10);
        checkOutput("rd_rdata", busIf.rsp_rdata, 32'h5A);
        checkOutput("rd_err", 32'(busIf.rsp_err), 32'd0);
        tick();
        checkOutput("rd_after_done", 32'(busIf.done), 32'd0);

        $display("[TB] contention, round robin");
        applyStimulus(2'b11, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1);
        busIf.Pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expAddr = (k % 2 == 0) ? 32'h10 : 32'h20;
            expDone = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checkOutput($sformatf("rr%0d_paddr", k), busIf.Paddr, expAddr);
            checkOutput($sformatf("rr%0d_pwdata", k), busIf.Pwdata,
                        (k % 2 == 0) ? 32'hA0 : 32'hB1);
            tick();
            checkOutput($sformatf("rr%0d_penable", k), 32'(busIf.Penable), 32'd1);
            tick();
            if (k == 3) busIf.req = 2'b00;
            checkOutput($sformatf("rr%0d_done", k), 32'(busIf.done), 32'(expDone));
            checkOutput($sformatf("rr%0d_rdata", k), busIf.rsp_rdata, 32'd0);
        end
        tick();
        checkOutput("rr_idle_psel", 32'(busIf.Psel), 32'd0);

        $display("[TB] slave error then clean transfer");
        applyStimulus(2'b01, 2'b01, 32'h08, 32'h0, 32'h11, 32'h0);
        busIf.Pready  = 1'b1;
        busIf.Pslverr = 1'b1;
        tick();
        tick();
        tick();
        busIf.Pslverr = 1'b0;
        checkOutput("err_done", 32'(busIf.done), 32'b01);
        checkOutput("err_flag", 32'(busIf.rsp_err), 32'd1);
        tick();
        checkOutput("err_next_setup", 32'(busIf.Psel), 32'd1);
        checkOutput("err_next_done_clear", 32'(busIf.done), 32'd0);
        tick();
        tick();
        busIf.req = 2'b00;
        checkOutput("err_next_done", 32'(busIf.done), 32'b01);
        checkOutput("err_next_flag", 32'(busIf.rsp_err), 32'd0);
        tick();

        $display("[TB] timeout");
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h30, 32'h0, 32'h0);
        busIf.Pready = 1'b0;
        busIf.Prdata = 32'h5A;
        tick();
        tick();
        checkOutput("to_access1", 32'(busIf.Penable), 32'd1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            checkOutput($sformatf("to_access%0d_psel", i), 32'(busIf.Psel), 32'd1);
        end
        tick();
        busIf.req = 2'b00;
        checkOutput("to_psel", 32'(busIf.Psel), 32'd0);
        checkOutput("to_penable", 32'(busIf.Penable), 32'd0);
        checkOutput("to_done", 32'(busIf.done), 32'b10);
        checkOutput("to_err", 32'(busIf.rsp_err), 32'd1);
        checkOutput("to_rdata", busIf.rsp_rdata, 32'd0);
        tick();
        checkOutput("to_after_done", 32'(busIf.done), 32'd0);

        $display("[TB] reset mid access");
        applyStimulus(2'b10, 2'b00, 32'h04, 32'h24, 32'h0, 32'h0);
        busIf.Pready = 1'b0;
        tick();
        tick();
        checkOutput("rst_mid_penable", 32'(busIf.Penable), 32'd1);
        Preset = 1'b1;
        tick();
        Preset = 1'b0;
        busIf.req = 2'b11;
        checkOutput("rst_mid_psel", 32'(busIf.Psel), 32'd0);
        checkOutput("rst_mid_pen", 32'(busIf.Penable), 32'd0);
        checkOutput("rst_mid_done", 32'(busIf.done), 32'd0);
        tick();
        checkOutput("rst_tie_psel", 32'(busIf.Psel), 32'd1);
        checkOutput("rst_tie_paddr", busIf.Paddr, 32'h04);
        busIf.Pready = 1'b1;
        tick();
        tick();
        busIf.req = 2'b00;
        checkOutput("rst_tie_done", 32'(busIf.done), 32'b01);
        tick();
        checkOutput("final_done", 32'(busIf.done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
